// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter between NREQ byte
//   sources. A grant is held for one packet (up to MAX_BURST bytes), and each
//   byte is handed to the UART with a one-cycle tx_start pulse.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to revoke a grant after
//   TIMEOUT idle cycles in GRANT (pulses timeout_err). Without it
//   timeout_err is tied low and a stalled owner keeps the grant.
//
// Ports
//   clk, reset     system clock, asynchronous active-high reset
//   req_valid      per-requester byte valid
//   req_data       byte of requester i at [i*DATA_W +: DATA_W]
//   req_last       per-requester last-byte-of-packet flag
//   req_ready      one-hot acceptance strobe (combinational)
//   grant          one-hot current owner, zero when idle
//   tx_data        byte to the UART, held until the next acceptance
//   tx_start       one-cycle start pulse to the UART
//   tx_busy        UART busy, high from the cycle after tx_start
//   timeout_err    one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter #(
  parameter int NREQ      = 3,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   timeout_err
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT, SEND, DRAIN} state_t;

  state_t            state, state_nx;
  logic [PTR_W-1:0]  ptr, ptr_nx;
  logic [PTR_W-1:0]  gidx, gidx_nx;
  logic [NREQ-1:0]   grant_nx;
  logic [3:0]        burst_cnt, burst_nx;
  logic [DATA_W-1:0] tx_data_nx;
  logic              last_q, last_nx;
  logic              drain_first;

  logic              sel_found;
  logic [PTR_W-1:0]  sel_idx;
  int unsigned       cand;
  logic              g_valid, g_last;
  logic [DATA_W-1:0] g_data;
  logic              handshake;
  logic              timeout_hit;

  // First valid requester after ptr, wrapping modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!sel_found && (j == cand) && req_valid[j]) begin
          sel_found = 1'b1;
          sel_idx   = PTR_W'(j);
        end
      end
    end
  end

  // Owner's inputs; other requesters are never looked at while granted.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == PTR_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign handshake = (state == GRANT) && g_valid && !tx_busy;
  assign req_ready = handshake ? grant : '0;
  assign tx_start  = (state == SEND);

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       timeout_q;

  assign timeout_hit = (state == GRANT) && !g_valid && (idle_cnt == 8'(TIMEOUT - 1));
  assign timeout_err = timeout_q;

  // Counter is cleared outside GRANT, so every entry to GRANT starts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_cnt  <= ((state == GRANT) && !g_valid && !timeout_hit) ? idle_cnt + 8'd1 : '0;
      timeout_q <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    gidx_nx    = gidx;
    grant_nx   = grant;
    burst_nx   = burst_cnt;
    tx_data_nx = tx_data;
    last_nx    = last_q;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_nx          = '0;
          grant_nx[sel_idx] = 1'b1;
          gidx_nx           = sel_idx;
          burst_nx          = '0;
          state_nx          = GRANT;
        end
      end
      GRANT: begin
        if (handshake) begin
          tx_data_nx = g_data;
          last_nx    = g_last;
          burst_nx   = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 4'd1;
          state_nx   = SEND;
        end else if (timeout_hit) begin
          ptr_nx   = gidx;
          grant_nx = '0;
          state_nx = IDLE;
        end
      end
      SEND: state_nx = DRAIN;
      DRAIN: begin
        // tx_busy only becomes valid one cycle after tx_start.
        if (!drain_first && !tx_busy) begin
          if (last_q || (burst_cnt == BURST_MAX)) begin
            ptr_nx   = gidx;
            grant_nx = '0;
            state_nx = IDLE;
          end else begin
            state_nx = GRANT;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= PTR_W'(NREQ - 1);
      gidx        <= '0;
      grant       <= '0;
      burst_cnt   <= '0;
      tx_data     <= '0;
      last_q      <= 1'b0;
      drain_first <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      gidx        <= gidx_nx;
      grant       <= grant_nx;
      burst_cnt   <= burst_nx;
      tx_data     <= tx_data_nx;
      last_q      <= last_nx;
      drain_first <= (state == SEND);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=3, MAX_BURST=4).
// A UART model holds tx_busy high for FRAME cycles after each tx_start.
// With FRAME busy cycles, bytes inside one packet start FRAME+3 cycles
// apart; across a release the IDLE cycle adds one more (FRAME+4).
module tb_uart_tx_arbiter;
  localparam int NREQ  = 3;
  localparam int FRAME = 10;
  localparam int TO    = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_last = '0;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        timeout_err;

  logic        force_busy = 1'b0;
  int          busy_cnt = 0;
  assign tx_busy = (busy_cnt != 0) || force_busy;

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(8), .MAX_BURST(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int hs_cyc = -1, hs_cnt = 0, to_cyc = -1, to_cnt = 0;
  logic [8:0] srcq [3][$];
  int         ev_cyc[$];
  logic [7:0] ev_data[$];
  logic [2:0] ev_grant[$];

  // UART busy model and source pops on accepted bytes.
  always @(posedge clk) begin
    cyc++;
    if (tx_start) busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
  end

  // Present queue heads, then sample outputs mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = 1'b0; req_last[i] = 1'b0; req_data[i*8 +: 8] = 8'h00;
      if (srcq[i].size() != 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = srcq[i][0][8];
        req_data[i*8 +: 8] = srcq[i][0][7:0];
      end
    end
    #1;
    if (tx_start) begin
      ev_cyc.push_back(cyc); ev_data.push_back(tx_data); ev_grant.push_back(grant);
    end
    if (timeout_err) begin to_cnt++; to_cyc = cyc; end
    if (req_ready != 0) begin hs_cyc = cyc; hs_cnt++; end
    checks++;
    if (((req_ready & ~grant) != 0) || ($countones(req_ready) > 1) || ((req_ready != 0) && tx_busy)) begin
      errors++;
      $display("FAIL ready_legal cyc=%0d req_ready=%b grant=%b tx_busy=%b", cyc, req_ready, grant, tx_busy);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset;
    @(posedge clk); #2; reset = 1'b1;
    @(posedge clk); #2; reset = 1'b0;
  endtask

  task automatic wait_events(input int n, output bit ok);
    int b = 0;
    while (ev_cyc.size() < n && b < 1000) begin @(posedge clk); #2; b++; end
    ok = (ev_cyc.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int b = 0;
    ok = 1'b0;
    while (!ok && b < 1000) begin
      if (grant == 0 && !tx_busy && srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0) ok = 1'b1;
      else begin @(posedge clk); #2; b++; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk); #2;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rst_grant got=%b exp=000", grant); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready got=%b exp=000", req_ready); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", timeout_err); end
    reset = 1'b0;
    @(posedge clk); #2;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL idle_grant got=%b exp=000", grant); end
  endtask

  task automatic test_single;
    bit ok; int base; logic [7:0] exp_d [3];
    exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
    base = ev_cyc.size();
    srcq[1].push_back({1'b0, 8'h41}); srcq[1].push_back({1'b0, 8'h42}); srcq[1].push_back({1'b1, 8'h43});
    wait_events(base + 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_events got=%0d exp=%0d", ev_cyc.size() - base, 3); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle got=busy exp=idle"); end
    checks++; if (ev_cyc.size() != base + 3) begin errors++; $display("FAIL single_count got=%0d exp=3", ev_cyc.size() - base); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ev_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL single_data%0d got=%h exp=%h", k, ev_data[base+k], exp_d[k]); end
      checks++; if (ev_grant[base+k] !== 3'b010) begin errors++; $display("FAIL single_grant%0d got=%b exp=010", k, ev_grant[base+k]); end
    end
    for (int k = 1; k < 3; k++) begin
      checks++; if (ev_cyc[base+k] - ev_cyc[base+k-1] != FRAME + 3) begin errors++; $display("FAIL single_gap%0d got=%0d exp=%0d", k, ev_cyc[base+k] - ev_cyc[base+k-1], FRAME + 3); end
    end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_release got=%b exp=000", grant); end
  endtask

  task automatic test_round_robin;
    bit ok; int base; logic [7:0] exp_d [4]; logic [2:0] exp_g [4];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB0; exp_d[2] = 8'hC0; exp_d[3] = 8'hA1;
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    apply_reset;
    base = ev_cyc.size();
    srcq[0].push_back({1'b1, 8'hA0}); srcq[0].push_back({1'b1, 8'hA1});
    srcq[1].push_back({1'b1, 8'hB0}); srcq[2].push_back({1'b1, 8'hC0});
    wait_events(base + 4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_events got=%0d exp=4", ev_cyc.size() - base); end
    wait_idle(ok);
    for (int k = 0; k < 4; k++) begin
      checks++; if (ev_grant[base+k] !== exp_g[k]) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, ev_grant[base+k], exp_g[k]); end
      checks++; if (ev_data[base+k] !== exp_d[k]) begin errors++; $display("FAIL rr_data%0d got=%h exp=%h", k, ev_data[base+k], exp_d[k]); end
      if (k > 0) begin
        checks++; if (ev_cyc[base+k] - ev_cyc[base+k-1] != FRAME + 4) begin errors++; $display("FAIL rr_gap%0d got=%0d exp=%0d", k, ev_cyc[base+k] - ev_cyc[base+k-1], FRAME + 4); end
      end
    end
  endtask

  task automatic test_burst;
    bit ok; int base; int exp_gap;
    base = ev_cyc.size();
    for (int k = 0; k < 10; k++) srcq[0].push_back({1'b0, 8'(8'h10 + k)});
    wait_events(base + 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_events got=%0d exp=10", ev_cyc.size() - base); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (ev_data[base+k] !== 8'(8'h10 + k)) begin errors++; $display("FAIL burst_data%0d got=%h exp=%h", k, ev_data[base+k], 8'(8'h10 + k)); end
      if (k > 0) begin
        exp_gap = (k == 4 || k == 8) ? FRAME + 4 : FRAME + 3;
        checks++; if (ev_cyc[base+k] - ev_cyc[base+k-1] != exp_gap) begin errors++; $display("FAIL burst_gap%0d got=%0d exp=%0d", k, ev_cyc[base+k] - ev_cyc[base+k-1], exp_gap); end
      end
    end
    repeat (40) @(posedge clk); #2;
`ifdef UART_ARB_TIMEOUT_EN
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL burst_revoked got=%b exp=000", grant); end
`else
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL burst_hold got=%b exp=001", grant); end
`endif
    apply_reset;
    wait_idle(ok);
  endtask

  task automatic test_reset_midframe;
    bit ok; int base; int s;
    apply_reset;
    base = ev_cyc.size();
    srcq[2].push_back({1'b1, 8'h55});
    wait_events(base + 1, ok);
    s = ev_cyc[base];
    while (cyc < s + 5) begin @(posedge clk); #2; end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", tx_busy); end
    reset = 1'b1; #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_grant got=%b exp=000", grant); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got=%h exp=00", tx_data); end
    checks++; if (tx_start !== 1'b0 || req_ready !== 3'b000) begin errors++; $display("FAIL mid_strobes got=%b/%b exp=0/000", tx_start, req_ready); end
    @(posedge clk); #2;
    reset = 1'b0;
    srcq[1].push_back({1'b1, 8'h66});
    wait_events(base + 2, ok);
    checks++; if (hs_cyc != s + FRAME + 1) begin errors++; $display("FAIL mid_handshake got=%0d exp=%0d", hs_cyc, s + FRAME + 1); end
    checks++; if (ev_data[base+1] !== 8'h66 || ev_grant[base+1] !== 3'b010) begin errors++; $display("FAIL mid_next got=%h/%b exp=66/010", ev_data[base+1], ev_grant[base+1]); end
    wait_idle(ok);
  endtask

  task automatic test_busy_hold;
    bit ok; int base; int c0; int hs0;
    base = ev_cyc.size();
    hs0 = hs_cnt;
    force_busy = 1'b1;
    c0 = cyc;
    srcq[0].push_back({1'b1, 8'h77});
    while (cyc < c0 + 50) begin
      @(posedge clk); #2;
      if (cyc == c0 + 25) begin
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL hold_grant got=%b exp=001", grant); end
      end
    end
    checks++; if (hs_cnt != hs0) begin errors++; $display("FAIL hold_no_ready got=%0d exp=%0d", hs_cnt, hs0); end
    force_busy = 1'b0;
    wait_events(base + 1, ok);
    checks++; if (hs_cyc != c0 + 50) begin errors++; $display("FAIL hold_handshake got=%0d exp=%0d", hs_cyc, c0 + 50); end
    checks++; if (ev_data[base] !== 8'h77) begin errors++; $display("FAIL hold_data got=%h exp=77", ev_data[base]); end
    wait_idle(ok);
  endtask

  task automatic test_drop_valid;
    bit ok; int base; int s; int to0;
    apply_reset;
    base = ev_cyc.size();
    to0 = to_cnt;
    srcq[2].push_back({1'b0, 8'h99});
    wait_events(base + 1, ok);
    s = ev_cyc[base];
    srcq[0].push_back({1'b1, 8'hAA});
`ifdef UART_ARB_TIMEOUT_EN
    wait_events(base + 2, ok);
    checks++; if (to_cnt != to0 + 1) begin errors++; $display("FAIL to_pulses got=%0d exp=%0d", to_cnt - to0, 1); end
    checks++; if (to_cyc != s + FRAME + 2 + TO) begin errors++; $display("FAIL to_cycle got=%0d exp=%0d", to_cyc, s + FRAME + 2 + TO); end
    checks++; if (ev_cyc[base+1] != to_cyc + 2) begin errors++; $display("FAIL to_regrant got=%0d exp=%0d", ev_cyc[base+1], to_cyc + 2); end
    checks++; if (ev_grant[base+1] !== 3'b001 || ev_data[base+1] !== 8'hAA) begin errors++; $display("FAIL to_next got=%b/%h exp=001/aa", ev_grant[base+1], ev_data[base+1]); end
`else
    while (cyc < s + 60) begin @(posedge clk); #2; end
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL drop_hold got=%b exp=100", grant); end
    checks++; if (to_cnt != to0) begin errors++; $display("FAIL drop_timeout got=%0d exp=0", to_cnt - to0); end
    checks++; if (ev_cyc.size() != base + 1) begin errors++; $display("FAIL drop_others got=%0d exp=1", ev_cyc.size() - base); end
    apply_reset;
`endif
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_drain got=busy exp=idle"); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_burst;
    test_reset_midframe;
    test_busy_hold;
    test_drop_valid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
